// File: rtl/trace_dump_ctrl_pkg.sv
// dso_pkg: shared types for the trace dump controller.
// Optional checksum byte is enabled with the TRACE_CHKSUM_EN macro.
package dso_pkg;

  localparam int TRACE_DEPTH = 512;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    SEND,
    CSUM,
    DONE
  } dump_state_t;

endpackage

// File: rtl/trace_dump_ctrl_if.sv
// trace_dump_ctrl_if: RAM port and UART byte stream of the dump controller.
// master = controller side, slave = RAM/UART side.
interface trace_dump_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] tx_data;
  logic              tx_vld;
  logic              tx_rdy;

  modport master (
    output ram_en,
    output ram_we,
    output ram_addr,
    output tx_data,
    output tx_vld,
    input  ram_rdata,
    input  tx_rdy
  );

  modport slave (
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  tx_data,
    input  tx_vld,
    output ram_rdata,
    output tx_rdy
  );

endinterface

// File: rtl/trace_dump_ctrl_ram_port_mux.sv
// ram_port_mux: capture port always wins the single RAM port;
// the dump read only proceeds when capture is idle.
module ram_port_mux #(
  parameter int ADDR_W = 9
) (
  input  logic              cap_en_i,
  input  logic              cap_we_i,
  input  logic [ADDR_W-1:0] cap_addr_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              rd_grant_o
);

  always_comb begin
    ram_en_o   = rd_req_i;
    ram_we_o   = 1'b0;
    ram_addr_o = rd_addr_i;
    if (cap_en_i) begin
      ram_en_o   = 1'b1;
      ram_we_o   = cap_we_i;
      ram_addr_o = cap_addr_i;
    end
  end

  assign rd_grant_o = rd_req_i & ~cap_en_i;

endmodule

// File: rtl/trace_dump_ctrl.sv
// trace_dump_ctrl: streams the circular trace buffer to the UART, oldest first.
// Define TRACE_CHKSUM_EN to append a two's-complement checksum byte.
module trace_dump_ctrl
  import dso_pkg::*;
#(
  parameter int ADDR_W = $clog2(TRACE_DEPTH),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en_i,
  input  logic              cap_we_i,
  input  logic [ADDR_W-1:0] cap_addr_i,
  input  logic              capture_done_i,
  input  logic [ADDR_W-1:0] trace_end_i,
  input  logic              dump_start_i,
  trace_dump_ctrl_if.master bus,
  output logic              dump_busy_o,
  output logic              dump_done_o,
  output logic              clr_capture_done_o,
  output logic              dump_err_o
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(2**ADDR_W - 1);

  dump_state_t       state_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_d;
  logic [ADDR_W:0]   cnt_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_vld_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              rd_req;
  logic              rd_grant;

`ifdef TRACE_CHKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;
  assign sum_d = sum_q + tx_data_q;
`endif

  assign rd_req   = (state_q == RD);
  assign rd_ptr_d = rd_ptr_q + ADDR_W'(1);

  ram_port_mux #(
    .ADDR_W (ADDR_W)
  ) u_mux (
    .cap_en_i   (cap_en_i),
    .cap_we_i   (cap_we_i),
    .cap_addr_i (cap_addr_i),
    .rd_req_i   (rd_req),
    .rd_addr_i  (rd_ptr_q),
    .ram_en_o   (bus.ram_en),
    .ram_we_o   (bus.ram_we),
    .ram_addr_o (bus.ram_addr),
    .rd_grant_o (rd_grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef TRACE_CHKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dump_start_i) begin
            if (capture_done_i) begin
              rd_ptr_q <= trace_end_i + ADDR_W'(1);
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= RD;
`ifdef TRACE_CHKSUM_EN
              sum_q    <= '0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        // a slot stolen by capture is simply retried
        RD: begin
          if (rd_grant) state_q <= LAT;
        end
        LAT: begin
          tx_data_q <= bus.ram_rdata;
          tx_vld_q  <= 1'b1;
          state_q   <= SEND;
        end
        SEND: begin
          if (bus.tx_rdy) begin
            tx_vld_q <= 1'b0;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_q + (ADDR_W+1)'(1);
`ifdef TRACE_CHKSUM_EN
            sum_q    <= sum_d;
`endif
            if (cnt_q == LAST) begin
`ifdef TRACE_CHKSUM_EN
              tx_data_q <= ~sum_d + DATA_W'(1);
              tx_vld_q  <= 1'b1;
              state_q   <= CSUM;
`else
              done_q  <= 1'b1;
              state_q <= DONE;
`endif
            end else begin
              state_q <= RD;
            end
          end
        end
`ifdef TRACE_CHKSUM_EN
        CSUM: begin
          if (bus.tx_rdy) begin
            tx_vld_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
`endif
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data        = tx_data_q;
  assign bus.tx_vld         = tx_vld_q;
  assign dump_busy_o        = busy_q;
  assign dump_done_o        = done_q;
  assign clr_capture_done_o = done_q;
  assign dump_err_o         = err_q;

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// tb_trace_dump_ctrl: randomized dumps checked by a queue scoreboard.
// Define TRACE_CHKSUM_EN to expect the trailing checksum byte.
module tb_trace_dump_ctrl;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int N  = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_en = 1'b0;
  logic          cap_we = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic          capture_done = 1'b0;
  logic [AW-1:0] trace_end = '0;
  logic          dump_start = 1'b0;
  logic          busy;
  logic          done;
  logic          clr;
  logic          err;

  trace_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  trace_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cap_en_i           (cap_en),
    .cap_we_i           (cap_we),
    .cap_addr_i         (cap_addr),
    .capture_done_i     (capture_done),
    .trace_end_i        (trace_end),
    .dump_start_i       (dump_start),
    .bus                (bus.master),
    .dump_busy_o        (busy),
    .dump_done_o        (done),
    .clr_capture_done_o (clr),
    .dump_err_o         (err)
  );

  always #5 clk = ~clk;

  // behavioural sample RAM: read data one cycle after the read
  logic [DW-1:0] mem [N];
  always @(posedge clk)
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];

  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] addr_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endfunction

  // monitor: samples on the falling edge
  logic [DW-1:0] prev_data = '0;
  logic          prev_stall = 1'b0;
  logic          last_hs = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      last_hs = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("vld_hold", 32'(bus.tx_vld), 32'(1));
        chk("data_hold", 32'(bus.tx_data), 32'(prev_data));
      end
      prev_stall = bus.tx_vld && !bus.tx_rdy;
      prev_data = bus.tx_data;
      last_hs = bus.tx_vld && bus.tx_rdy;
      if (last_hs) begin
        if (exp_q.size() == 0) chk("tx_unexpected", 32'(1), 32'(0));
        else chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
      if (cap_en) begin
        chk("mux_en", 32'(bus.ram_en), 32'(1));
        chk("mux_we", 32'(bus.ram_we), 32'(cap_we));
        chk("mux_addr", 32'(bus.ram_addr), 32'(cap_addr));
      end else if (bus.ram_en) begin
        chk("rd_we", 32'(bus.ram_we), 32'(0));
        if (addr_q.size() == 0) chk("rd_unexpected", 32'(1), 32'(0));
        else chk("rd_addr", 32'(bus.ram_addr), 32'(addr_q.pop_front()));
      end
      if (done || clr) begin
        chk("clr_with_done", 32'(clr), 32'(done));
        done_cnt++;
      end
      if (err) err_cnt++;
    end
  end

  // driver for tx_rdy and capture traffic
  int rdy_pct = 100;
  bit cap_rand = 1'b0;
  bit stall_req = 1'b0;
  bit capf_req = 1'b0;
  int stall_left = 0;
  int capf_left = 0;

  initial begin
    bus.tx_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_left > 0) stall_left--;
      else if (stall_req && bus.tx_vld) begin
        stall_left = 20;
        stall_req = 1'b0;
      end
      bus.tx_rdy = (stall_left == 0) && ($urandom_range(99) < rdy_pct);
      if (capf_left > 0) capf_left--;
      else if (capf_req && last_hs) begin
        capf_left = 5;
        capf_req = 1'b0;
      end
      if (capf_left > 0 || (cap_rand && $urandom_range(7) == 0)) begin
        cap_en = 1'b1;
        cap_we = 1'($urandom);
        cap_addr = AW'($urandom);
      end else begin
        cap_en = 1'b0;
      end
    end
  end

  // reference stream: oldest sample first, starting after trace_end
  task automatic load_model(input logic [AW-1:0] te);
    int a;
    int s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      a = (int'(te) + 1 + i) % N;
      addr_q.push_back(AW'(a));
      exp_q.push_back(mem[a]);
      s = s + int'(mem[a]);
    end
`ifdef TRACE_CHKSUM_EN
    exp_q.push_back(DW'((256 - (s % 256)) % 256));
`endif
  endtask

  task automatic do_dump(input logic [AW-1:0] te, input bit poke,
                         input bit drop_cd);
    int base;
    int to;
    trace_end = te;
    capture_done = 1'b1;
    load_model(te);
    base = done_cnt;
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    chk("busy_on_start", 32'(busy), 32'(1));
    if (poke || drop_cd) begin
      repeat (40) @(posedge clk);
      #1;
      if (drop_cd) capture_done = 1'b0;
      if (poke) begin
        dump_start = 1'b1;
        @(posedge clk);
        #1;
        dump_start = 1'b0;
      end
    end
    to = 0;
    while (done_cnt == base && to < 20000) begin
      @(posedge clk);
      to++;
    end
    chk("dump_timeout", 32'(to < 20000), 32'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_cnt - base), 32'(1));
    chk("bytes_left", 32'(exp_q.size()), 32'(0));
    chk("reads_left", 32'(addr_q.size()), 32'(0));
    chk("busy_after", 32'(busy), 32'(0));
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
  endtask

  initial begin
    int base;
    for (int i = 0; i < N; i++) mem[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_clr", 32'(clr), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_vld", 32'(bus.tx_vld), 32'(0));
    chk("rst_data", 32'(bus.tx_data), 32'(0));
    chk("rst_ram_en", 32'(bus.ram_en), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // rejected start: error pulse, no RAM access
    capture_done = 1'b0;
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    chk("err_pulse", 32'(err), 32'(1));
    chk("err_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(err), 32'(0));
    repeat (5) @(posedge clk);
    #1;

    fill_rand();
    do_dump(AW'(9'h0A0), 1'b0, 1'b0);

    fill_rand();
    rdy_pct = 60;
    cap_rand = 1'b1;
    stall_req = 1'b1;
    capf_req = 1'b1;
    do_dump(AW'(9'h1FF), 1'b1, 1'b0);

    fill_rand();
    rdy_pct = 80;
    do_dump(AW'($urandom), 1'b0, 1'b1);

    // reset in the middle of a dump
    fill_rand();
    trace_end = AW'($urandom);
    capture_done = 1'b1;
    load_model(trace_end);
    dump_start = 1'b1;
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    cap_rand = 1'b0;
    base = done_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_vld", 32'(bus.tx_vld), 32'(0));
    chk("mid_rst_data", 32'(bus.tx_data), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_clr", 32'(clr), 32'(0));
    exp_q.delete();
    addr_q.delete();
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(done_cnt - base), 32'(0));
    chk("no_busy_after_rst", 32'(busy), 32'(0));

    // constant contents: checksum of 512 ones, then one 0x05
    rdy_pct = 100;
    for (int i = 0; i < N; i++) mem[i] = DW'(1);
    do_dump(AW'($urandom), 1'b0, 1'b0);
    mem[$urandom_range(N-1)] = DW'(5);
    do_dump(AW'($urandom), 1'b0, 1'b0);

    chk("err_count", 32'(err_cnt), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_dump_ctrl.md
Name: trace_dump_ctrl

Overview:
- Owns the single-port sample RAM and shares it between two requesters: the capture write path and a dump reader that streams a finished trace to the UART transmitter.
- Capture has absolute priority.
- The dump unloads the circular buffer oldest-first, starting at trace_end+1 and wrapping.
- On completion it clears capture_done so the capture unit can re-arm.

Parameters:
- ADDR_W, 9, RAM address width; trace depth = 2**ADDR_W.
- DATA_W, 8, sample width; equals the UART byte width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous active-low
- cap_en  in  1  capture RAM enable request
- cap_we  in  1  capture write strobe (qualified by cap_en)
- cap_addr  in  ADDR_W  capture write address
- capture_done  in  1  trace complete, from capture unit
- trace_end  in  ADDR_W  address of the last sample written
- dump_start  in  1  one-cycle request from the command processor
- tx_rdy  in  1  UART can accept a byte this cycle
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- tx_data  out  DATA_W  byte to UART
- tx_vld  out  1  tx_data valid; held until tx_rdy
- dump_busy  out  1  dump in progress
- dump_done  out  1  one-cycle pulse at end of dump
- clr_capture_done  out  1  one-cycle pulse, coincident with dump_done
- dump_err  out  1  one-cycle pulse when dump_start is rejected

Behaviour:
- Reset values: every registered output 0; state IDLE; rd_ptr 0; cnt 0. A reset mid-dump aborts immediately with no dump_done.
- Mux (combinational):
  - cap_en=1: ram_en=1, ram_we=cap_we, ram_addr=cap_addr.
  - Otherwise the dump port drives ram_en=rd_req, ram_we=0, ram_addr=rd_ptr.
- States:
  - IDLE:
    - dump_start & capture_done: rd_ptr<=trace_end+1 (mod 2**ADDR_W; trace_end=511 gives 0), cnt<=0, go to RD.
    - dump_start & ~capture_done: dump_err pulse, stay in IDLE.
  - RD: rd_req=1.
    - If cap_en=1 the slot is lost; stay in RD and retry next cycle.
    - Otherwise go to LAT.
  - LAT: register ram_rdata into tx_data, assert tx_vld, go to SEND.
  - SEND: tx_vld held.
    - On tx_rdy: tx_vld<=0, rd_ptr<=rd_ptr+1 (wraps), cnt<=cnt+1.
    - If cnt was 2**ADDR_W-1, go to DONE; otherwise go to RD.
  - DONE: dump_done=1 and clr_capture_done=1 for one cycle, then IDLE.
- Widths and ordering:
  - cnt is ADDR_W+1 bits.
  - Exactly 2**ADDR_W bytes are sent per dump, oldest sample first.
- Busy and handshake rules:
  - dump_busy=1 in every state except IDLE.
  - dump_start while busy is ignored, with no dump_err.
  - tx_data must be stable while tx_vld=1.
  - Minimum of 3 cycles per byte when tx_rdy is already high.
- Simultaneous events:
  - cap_en and rd_req in the same cycle: capture wins, and the read is retried.
  - capture_done falling mid-dump is ignored; the dump completes.

Optional Feature:
- Macro: TRACE_CHKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of all sent bytes is kept.
  - After the last sample, state CSUM drives tx_data = ~sum + 1 (two's complement) with tx_vld until tx_rdy, then goes to DONE.
  - Total of 2**ADDR_W+1 bytes; the byte-sum of the whole stream is 0.
- Undefined: no CSUM state and no sum register; SEND goes straight to DONE.

Decomposition:
- Package dso_pkg holds:
  - typedef enum dump_state_t {IDLE, RD, LAT, SEND, CSUM, DONE};
  - localparam TRACE_DEPTH=512.
- One sub-module, ram_port_mux: purely combinational priority mux of the capture and dump ports onto the RAM. It also emits rd_grant = rd_req & ~cap_en.
- The FSM, pointer and counters stay in the top module.

Test Plan:
- trace_end=0x0A0, capture_done=1, dump_start, tx_rdy=1:
  - 512 tx_vld handshakes with addresses 0x0A1..0x1FF, then 0x000..0x0A0.
  - dump_done and clr_capture_done pulse together once.
- trace_end=0x1FF:
  - First read address is 0x000, last is 0x1FF.
- cap_en forced high 5 cycles during an RD state:
  - ram_addr=cap_addr and ram_we=cap_we for those cycles.
  - The read retries at the same rd_ptr; no byte is skipped or duplicated.
- tx_rdy held low 20 cycles in SEND:
  - tx_vld and tx_data are stable throughout; rd_ptr does not advance.
- dump_start with capture_done=0 gives a dump_err pulse and no RAM access.
- dump_start while busy is ignored.
- rst_n=0 mid-dump:
  - Next cycle all outputs are 0, state is IDLE, and there is no dump_done.
- With TRACE_CHKSUM_EN:
  - RAM holds bytes 0x01 at every address.
  - The 513th byte is 0x00 (512 mod 256 = 0, negated is 0).
  - With one extra 0x05 in place of one 0x01, the final byte is 0xFC.
